// File: rtl/insn_byte_fifo.sv
// insn_byte_fifo: show-ahead instruction byte FIFO with early full for in-flight fetches
module insn_byte_fifo #(
   parameter int DEPTH       = 8,
   parameter int FULL_MARGIN = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    wr_en,
   input  logic [7:0]              wr_data,
   output logic                    wr_full,
   input  logic                    rd_en,
   output logic [7:0]              rd_data,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_MAX  = (AW+1)'(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH - FULL_MARGIN);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_level;
   logic          r_overflow;
   logic          w_at_max;
   logic          w_rd_ok;
   logic          w_wr_ok;
   logic          w_ovf;

   // Acceptance: flush discards both sides; a full FIFO still takes a write when a read frees a slot
   always_comb begin
      w_at_max = r_level == LVL_MAX;
      w_rd_ok  = rd_en && !flush && r_level != '0;
      w_wr_ok  = wr_en && !flush && (!w_at_max || w_rd_ok);
      w_ovf    = wr_en && !flush && w_at_max && !w_rd_ok;
   end

   // Byte storage, intentionally not reset
   always_ff @(posedge clk)
      if (w_wr_ok) r_mem[r_wr_ptr] <= wr_data;

   // Pointers and fill level; pointers wrap modulo DEPTH
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_level  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         r_level <= r_level + (AW+1)'(w_wr_ok) - (AW+1)'(w_rd_ok);
      end

   // Sticky overflow flag, survives flush so upstream protocol violations stay visible
   always_ff @(posedge clk or posedge reset)
      if (reset) r_overflow <= 1'b0;
      else if (w_ovf) r_overflow <= 1'b1;

   assign rd_data  = r_mem[r_rd_ptr];
   assign empty    = r_level == '0;
   assign wr_full  = r_level >= LVL_FULL;
   assign level    = r_level;
   assign overflow = r_overflow;
endmodule

// File: tb/tb_insn_byte_fifo.sv
// tb_insn_byte_fifo: directed and randomized checks of insn_byte_fifo against a queue model
module tb_insn_byte_fifo;
   localparam int DEPTH = 8;
   localparam int MARGIN = 2;

   logic       clk = 0;
   logic       reset = 1;
   logic       flush = 0;
   logic       wr_en = 0;
   logic [7:0] wr_data = 0;
   logic       wr_full;
   logic       rd_en = 0;
   logic [7:0] rd_data;
   logic       empty;
   logic [3:0] level;
   logic       overflow;

   int n_chk = 0;
   int n_pass = 0;
   logic [7:0] q[$];
   bit ovf = 0;

   insn_byte_fifo #(.DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
      .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .wr_full(wr_full), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
      .level(level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".level"}, 32'(level), 32'(q.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
      chk({tag, ".full"}, 32'(wr_full), 32'(q.size() >= DEPTH - MARGIN));
      chk({tag, ".ovf"}, 32'(overflow), 32'(ovf));
      if (q.size() > 0) chk({tag, ".data"}, 32'(rd_data), 32'(q[0]));
   endtask

   task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit f, input string tag);
      bit rd_ok, wr_ok;
      wr_en = w; wr_data = d; rd_en = r; flush = f;
      rd_ok = r && !f && q.size() > 0;
      wr_ok = w && !f && (q.size() < DEPTH || rd_ok);
      if (w && !f && q.size() == DEPTH && !rd_ok) ovf = 1;
      @(posedge clk); #1;
      if (f) q.delete();
      else begin
         if (rd_ok) void'(q.pop_front());
         if (wr_ok) q.push_back(d);
      end
      wr_en = 0; rd_en = 0; flush = 0;
      check_all(tag);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst.level", 32'(level), 0);
      chk("rst.empty", 32'(empty), 1);
      chk("rst.full", 32'(wr_full), 0);
      chk("rst.ovf", 32'(overflow), 0);
      reset = 0;
      @(posedge clk); #1;
      // 1: basic write then show-ahead read
      cycle(1, 8'h11, 0, 0, "t1w0");
      cycle(1, 8'h22, 0, 0, "t1w1");
      cycle(1, 8'h33, 0, 0, "t1w2");
      chk("t1.head", 32'(rd_data), 32'h11);
      cycle(0, 0, 1, 0, "t1r");
      chk("t1.next", 32'(rd_data), 32'h22);
      // 2: full threshold, fill to DEPTH, overflow on 9th
      cycle(0, 0, 0, 1, "t2f");
      for (int i = 0; i < 8; i++) cycle(1, 8'(8'h40 + i), 0, 0, "t2w");
      chk("t2.lvl8", 32'(level), 8);
      chk("t2.noovf", 32'(overflow), 0);
      cycle(1, 8'hEE, 0, 0, "t2w9");
      chk("t2.ovf", 32'(overflow), 1);
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, "t2r");
      // 3: steady-state simultaneous read/write across wrap
      for (int i = 0; i < 4; i++) cycle(1, 8'(i), 0, 0, "t3fill");
      for (int i = 0; i < 20; i++) cycle(1, 8'(4 + i), 1, 0, "t3rw");
      chk("t3.lvl", 32'(level), 4);
      // 4: flush at level 5 beats concurrent read/write
      cycle(1, 8'h77, 0, 0, "t4fill");
      cycle(1, 8'h99, 1, 1, "t4flush");
      chk("t4.empty", 32'(empty), 1);
      cycle(1, 8'hAB, 0, 0, "t4w");
      chk("t4.head", 32'(rd_data), 32'hAB);
      cycle(0, 0, 1, 0, "t4r");
      // 5: reads on empty ignored
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, "t5r");
      cycle(1, 8'h5A, 0, 0, "t5w");
      chk("t5.head", 32'(rd_data), 32'h5A);
      cycle(0, 0, 1, 0, "t5r2");
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit w, r, f;
         w = $urandom_range(0, 9) < 6;
         r = $urandom_range(0, 9) < 5;
         f = $urandom_range(0, 99) < 3;
         if (f && q.size() == DEPTH) w = 0;
         cycle(w, 8'($urandom), r, f, "rnd");
      end
      // 6: async reset at level 7 with overflow set
      cycle(0, 0, 0, 1, "t6f");
      for (int i = 0; i < 9; i++) cycle(1, 8'(8'hC0 + i), 0, 0, "t6w");
      cycle(0, 0, 1, 0, "t6r");
      chk("t6.lvl7", 32'(level), 7);
      chk("t6.ovf1", 32'(overflow), 1);
      #2 reset = 1;
      #1;
      q.delete(); ovf = 0;
      chk("t6.alevel", 32'(level), 0);
      chk("t6.aempty", 32'(empty), 1);
      chk("t6.afull", 32'(wr_full), 0);
      chk("t6.aovf", 32'(overflow), 0);
      @(posedge clk); #1;
      reset = 0;
      cycle(1, 8'h3C, 0, 0, "t6resume");
      chk("t6.head", 32'(rd_data), 32'h3C);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
